// File: rtl/arith_defs_pkg.sv
// Shared arithmetic definitions: operand width, FSM encodings, counter width.
package arith_defs;

    localparam int unsigned BITS  = 32;
    localparam int unsigned CNT_W = $clog2(BITS) + 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } mul_state_e;

endpackage

// File: rtl/thirtytwo_bit_adder.sv
// Unsigned ripple-style adder with carry in/out; the 33-bit result is exact.
module thirtytwo_bit_adder #(
    parameter int unsigned Width = 32
) (
    input  logic [Width-1:0] A,
    input  logic [Width-1:0] B,
    input  logic             CarryIN,
    output logic [Width-1:0] Sum,
    output logic             CarryOUT
);

    // Widen by one bit so the carry out is captured alongside the sum
    assign {CarryOUT, Sum} = {1'b0, A} + {1'b0, B} + {{Width{1'b0}}, CarryIN};

endmodule

// File: rtl/thirtytwo_bit_multiplier.sv
// Sequential unsigned shift-and-add multiplier with Start/Busy/Done handshake.
// One partial-product add per cycle through the shared adder; result after Bits iterations.
module thirtytwo_bit_multiplier
    import arith_defs::*;
#(
    parameter int unsigned Bits = BITS
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic [Bits-1:0]   A,
    input  logic [Bits-1:0]   B,
    output logic              Busy,
    output logic              Done,
    output logic [2*Bits-1:0] Product
);

    localparam int unsigned CntW = $clog2(Bits) + 1;

    mul_state_e      state;
    logic [Bits-1:0] m;
    logic [Bits-1:0] p_hi;
    logic [Bits-1:0] p_lo;
    logic [CntW-1:0] cnt;

    logic [Bits-1:0] add_b;
    logic [Bits-1:0] sum;
    logic            carry_out;

    // Add the multiplicand only when the current multiplier LSB is set
    assign add_b = p_lo[0] ? m : '0;

    thirtytwo_bit_adder #(
        .Width (Bits)
    ) u_adder (
        .A        (p_hi),
        .B        (add_b),
        .CarryIN  (1'b0),
        .Sum      (sum),
        .CarryOUT (carry_out)
    );

    assign Product = {p_hi, p_lo};

    // FSM, iteration counter and datapath registers with registered Busy/Done
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= StIdle;
            Busy  <= 1'b0;
            Done  <= 1'b0;
            m     <= '0;
            p_hi  <= '0;
            p_lo  <= '0;
            cnt   <= '0;
        end else begin
            unique case (state)
                StIdle, StDone: begin
                    Done <= 1'b0;
                    if (Start) begin
                        m     <= A;
                        p_lo  <= B;
                        p_hi  <= '0;
                        cnt   <= '0;
                        state <= StRun;
                        Busy  <= 1'b1;
                    end else begin
                        state <= StIdle;
                        Busy  <= 1'b0;
                    end
                end
                StRun: begin
                    // Shift the 33-bit partial sum down one place into {P_hi,P_lo}
                    p_hi <= {carry_out, sum[Bits-1:1]};
                    p_lo <= {sum[0], p_lo[Bits-1:1]};
                    cnt  <= cnt + CntW'(1);
                    if (cnt == CntW'(Bits - 1)) begin
                        state <= StDone;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                    end
                end
                default: begin
                    state <= StIdle;
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_thirtytwo_bit_multiplier.sv
// Directed and randomised checks of the sequential multiplier.
module tb_thirtytwo_bit_multiplier;

    logic        Clock;
    logic        Reset;
    logic        Start;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic        Done;
    logic [63:0] Product;

    int n_cmp;
    int n_err;

    thirtytwo_bit_multiplier dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Start   (Start),
        .A       (A),
        .B       (B),
        .Busy    (Busy),
        .Done    (Done),
        .Product (Product)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one op; sample each negedge after the accept edge (j=0 is the first).
    // abort_at >= 0 pulses Reset at that sample and checks the immediate clear.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int abort_at,
                          output logic [63:0] prod, output bit got_done,
                          output int done_j, output int busy_n);
        prod     = '0;
        got_done = 1'b0;
        done_j   = -1;
        busy_n   = 0;
        @(negedge Clock);
        A = a;
        B = b;
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        for (int j = 0; j < 40; j++) begin
            if (j == abort_at) begin
                Reset = 1'b1;
                #1;
                check("abort_busy", {63'd0, Busy}, 64'd0);
                check("abort_done", {63'd0, Done}, 64'd0);
                check("abort_prod", Product, 64'd0);
                @(negedge Clock);
                check("abort_held_done", {63'd0, Done}, 64'd0);
                Reset = 1'b0;
                return;
            end
            if (Busy) busy_n++;
            if (Done) begin
                got_done = 1'b1;
                done_j   = j;
                prod     = Product;
                return;
            end
            @(negedge Clock);
        end
    endtask

    logic [63:0] prod;
    bit          got_done;
    int          done_j;
    int          busy_n;
    int          n_rand;

    initial begin
        n_cmp = 0;
        n_err = 0;
        Reset = 1'b1;
        Start = 1'b0;
        A     = '0;
        B     = '0;
        #12;
        check("rst_busy", {63'd0, Busy}, 64'd0);
        check("rst_done", {63'd0, Done}, 64'd0);
        check("rst_prod", Product, 64'd0);
        @(negedge Clock);
        Reset = 1'b0;

        // 1: reset mid-run, then a clean op
        run_op(32'hFFFF_FFFF, 32'h1234_5678, 10, prod, got_done, done_j, busy_n);
        check("t1_nodone", {63'd0, got_done}, 64'd0);
        run_op(32'd3, 32'd5, -1, prod, got_done, done_j, busy_n);
        check("t1_done", {63'd0, got_done}, 64'd1);
        check("t1_prod", prod, 64'd15);

        // 2: latency and Busy width
        run_op(32'd7, 32'd6, -1, prod, got_done, done_j, busy_n);
        check("t2_prod", prod, 64'd42);
        check("t2_busy_cycles", 64'(busy_n), 64'd32);
        check("t2_done_edge", 64'(done_j), 64'd32);
        @(negedge Clock);
        check("t2_done_pulse", {63'd0, Done}, 64'd0);
        check("t2_idle_busy", {63'd0, Busy}, 64'd0);
        check("t2_hold_prod", Product, 64'd42);

        // 3: all-ones operands
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, prod, got_done, done_j, busy_n);
        check("t3_prod", prod, 64'hFFFF_FFFE_0000_0001);

        // 4: carry into high word, then zero multiplicand
        run_op(32'h8000_0000, 32'd2, -1, prod, got_done, done_j, busy_n);
        check("t4a_prod", prod, 64'h0000_0001_0000_0000);
        run_op(32'd0, 32'hDEAD_BEEF, -1, prod, got_done, done_j, busy_n);
        check("t4b_prod", prod, 64'd0);
        run_op(32'hDEAD_BEEF, 32'd0, -1, prod, got_done, done_j, busy_n);
        check("t4c_prod", prod, 64'd0);

        // 5: Start held high, operands toggling; back-to-back accept in DONE
        @(negedge Clock);
        A = 32'd9;
        B = 32'd9;
        Start = 1'b1;
        done_j = -1;
        for (int j = 0; j < 40; j++) begin
            @(negedge Clock);
            if (Done) begin
                done_j = j;
                break;
            end
            A = $urandom;
            B = $urandom;
        end
        check("t5_done_edge", 64'(done_j), 64'd32);
        check("t5_prod", Product, 64'd81);
        A = 32'd4;
        B = 32'd5;
        @(negedge Clock);
        check("t5_b2b_busy", {63'd0, Busy}, 64'd1);
        done_j = -1;
        for (int j = 1; j < 40; j++) begin
            A = $urandom;
            B = $urandom;
            @(negedge Clock);
            if (Done) begin
                done_j = j;
                break;
            end
        end
        Start = 1'b0;
        check("t5_b2b_done_edge", 64'(done_j), 64'd32);
        check("t5_b2b_prod", Product, 64'd20);
        @(negedge Clock);

        // 6: random operands with occasional reset aborts
        n_rand = 0;
        for (int i = 0; i < 1000; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            int          ab;
            ra = $urandom;
            rb = $urandom;
            ab = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 31)) : -1;
            run_op(ra, rb, ab, prod, got_done, done_j, busy_n);
            if (ab >= 0) begin
                check("t6_abort_nodone", {63'd0, got_done}, 64'd0);
            end else begin
                check("t6_done", {63'd0, got_done}, 64'd1);
                check("t6_prod", prod, {32'd0, ra} * {32'd0, rb});
                n_rand++;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
